ufunc_call_f4_mul_arb: RTL and testbench

//  Shares one pipelined 15x15 unsigned multiplier (ufunc_call_f4_mul_mul_15ns_15ns_30_4_1) among NUM_REQ requesters.

---
 rtl/ufunc_call_f4_pkg.sv | 8 +
 rtl/ufunc_call_f4_mul_mul_15ns_15ns_30_4_1.sv | 29 ++
 rtl/ufunc_call_f4_mul_arb.sv | 81 ++++++++
 tb/tb_ufunc_call_f4_mul_arb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ufunc_call_f4_pkg.sv
// ufunc_call_f4_pkg: shared widths, multiplier depth and requester id type
package ufunc_call_f4_pkg;
    localparam int MUL_IN_W  = 15;
    localparam int MUL_OUT_W = 30;
    localparam int MUL_LAT   = 3;
    localparam int MAX_ID_W  = 3;
    typedef logic [MAX_ID_W-1:0] req_id_t;
endpackage

// File: rtl/ufunc_call_f4_mul_mul_15ns_15ns_30_4_1.sv
// ufunc_call_f4_mul_mul_15ns_15ns_30_4_1: 3-stage pipelined 15x15 unsigned multiplier with clock enable
module ufunc_call_f4_mul_mul_15ns_15ns_30_4_1
    import ufunc_call_f4_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic [MUL_IN_W-1:0]  din0,
    input  logic [MUL_IN_W-1:0]  din1,
    output logic [MUL_OUT_W-1:0] dout
);
    logic [MUL_IN_W-1:0]  a_reg, b_reg;
    logic [MUL_OUT_W-1:0] p_reg_tmp, p_reg;
    logic                 unused_reset;

    assign unused_reset = reset;

    // operand capture, multiply, output register; frozen while ce is low
    always_ff @(posedge clk) begin
        if (ce) begin
            a_reg     <= din0;
            b_reg     <= din1;
            p_reg_tmp <= MUL_OUT_W'(a_reg) * MUL_OUT_W'(b_reg);
            p_reg     <= p_reg_tmp;
        end
    end

    assign dout = p_reg;
endmodule

// File: rtl/ufunc_call_f4_mul_arb.sv
// ufunc_call_f4_mul_arb: round-robin sharing of one pipelined multiplier among NUM_REQ requesters
module ufunc_call_f4_mul_arb
    import ufunc_call_f4_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*MUL_IN_W-1:0]   req_a,
    input  logic [NUM_REQ*MUL_IN_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [MUL_OUT_W-1:0]          rsp_data,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic                          busy
);
    localparam int LAT = MUL_LAT;

    logic [LAT-1:0]      vld;
    logic [ID_W-1:0]     tag [LAT];
    logic [ID_W-1:0]     rr_ptr, gnt, idx;
    logic                found, ce, accept;
    logic [MUL_IN_W-1:0] din0, din1;

    // a result waiting on a not-ready requester freezes the whole pipe
    assign ce     = ~(vld[LAT-1] & ~rsp_ready[tag[LAT-1]]);
    assign accept = found & ce & reset_n;

    // first valid requester at or after rr_ptr, wrapping; lowest offset wins
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign req_ready = accept ? NUM_REQ'(1) << gnt : '0;
    assign din0      = found ? req_a[gnt*MUL_IN_W +: MUL_IN_W] : '0;
    assign din1      = found ? req_b[gnt*MUL_IN_W +: MUL_IN_W] : '0;

    // valid/tag pipe tracks the multiplier stages; rr pointer moves past each winner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld    <= '0;
            rr_ptr <= '0;
            for (int k = 0; k < LAT; k++) tag[k] <= '0;
        end else begin
            if (ce) begin
                vld    <= {vld[LAT-2:0], accept};
                tag[0] <= gnt;
                for (int k = 1; k < LAT; k++) tag[k] <= tag[k-1];
            end
            if (accept) rr_ptr <= (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
        end
    end

    // route the head-of-pipe result to its issuing requester
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] = vld[LAT-1] && (int'(tag[LAT-1]) == i);
    end

    assign busy = |vld;

    ufunc_call_f4_mul_mul_15ns_15ns_30_4_1 u_mul (
        .clk   (clk),
        .reset (~reset_n),
        .ce    (ce),
        .din0  (din0),
        .din1  (din1),
        .dout  (rsp_data)
    );
endmodule

// File: tb/tb_ufunc_call_f4_mul_arb.sv
// tb_ufunc_call_f4_mul_arb: scenario tasks plus issue-order scoreboard for the shared multiplier
module tb_ufunc_call_f4_mul_arb;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [59:0] req_a = '0;
    logic [59:0] req_b = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [29:0] rsp_data;
    logic [3:0]  rsp_ready = 4'b1111;
    logic        busy;

    typedef logic [31:0] ent_t;
    ent_t exp_q[$];
    ent_t obs_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   rsp_seen = 0;

    always #5 clk = ~clk;

    ufunc_call_f4_mul_arb #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // one cycle: record accepts (expected products) and result handshakes at mid-cycle
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i])
                exp_q.push_back({2'(i), 30'(req_a[i*15 +: 15]) * 30'(req_b[i*15 +: 15])});
            if (rsp_valid[i] && rsp_ready[i])
                obs_q.push_back({2'(i), rsp_data});
        end
        if (rsp_valid != 4'b0) rsp_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [14:0] a, input logic [14:0] b);
        req_a[i*15 +: 15] = a;
        req_b[i*15 +: 15] = b;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total_cnt++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready got %b exp 0000", req_ready); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        reset_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_single();
        for (int c = 0; c < 5; c++) begin
            req_valid = (c == 0) ? 4'b0001 : 4'b0000;
            set_op(0, 15'd3, 15'd5);
            #1;
            if (c == 0) begin
                total_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_grant got %b exp 0001", req_ready); else pass_cnt++;
            end
            total_cnt++; if (busy !== (c >= 1 && c <= 3)) $display("FAIL single_busy c%0d got %b", c, busy); else pass_cnt++;
            total_cnt++; if (rsp_valid !== ((c == 3) ? 4'b0001 : 4'b0000)) $display("FAIL single_rsp_valid c%0d got %b", c, rsp_valid); else pass_cnt++;
            if (c == 3) begin
                total_cnt++; if (rsp_data !== 30'd15) $display("FAIL single_data got %0d exp 15", rsp_data); else pass_cnt++;
            end
            tick();
        end
        total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL single_count got %0d exp %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            total_cnt++; if (obs_q[k] !== exp_q[k]) $display("FAIL single_sb[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); else pass_cnt++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_max();
        for (int c = 0; c < 5; c++) begin
            req_valid = (c == 0) ? 4'b1000 : 4'b0000;
            set_op(3, 15'h7FFF, 15'h7FFF);
            #1;
            if (c == 3) begin
                total_cnt++; if (rsp_valid !== 4'b1000) $display("FAIL max_rsp_valid got %b exp 1000", rsp_valid); else pass_cnt++;
                total_cnt++; if (rsp_data !== 30'h3FFF0001) $display("FAIL max_data got %h exp 3fff0001", rsp_data); else pass_cnt++;
            end
            tick();
        end
        total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL max_count got %0d exp %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            total_cnt++; if (obs_q[k] !== exp_q[k]) $display("FAIL max_sb[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); else pass_cnt++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_round_robin();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 15'(i + 1), 15'd10);
        for (int c = 0; c < 12; c++) begin
            req_valid = 4'b1111;
            #1;
            total_cnt++; if (req_ready !== 4'(1 << (c % 4))) $display("FAIL rr_grant c%0d got %b exp %b", c, req_ready, 4'(1 << (c % 4))); else pass_cnt++;
            if (c >= 3) begin
                total_cnt++; if (rsp_valid !== 4'(1 << ((c - 3) % 4))) $display("FAIL rr_rsp_valid c%0d got %b", c, rsp_valid); else pass_cnt++;
                total_cnt++; if (rsp_data !== 30'(((c - 3) % 4 + 1) * 10)) $display("FAIL rr_data c%0d got %0d exp %0d", c, rsp_data, ((c - 3) % 4 + 1) * 10); else pass_cnt++;
            end
            tick();
        end
        req_valid = 4'b0000;
        repeat (4) tick();
        total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL rr_count got %0d exp %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            total_cnt++; if (obs_q[k] !== exp_q[k]) $display("FAIL rr_sb[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); else pass_cnt++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 4; i++) set_op(i, 15'(100 + i), 15'(7 + i));
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < 10) ? 4'b1111 : 4'b0000;
            rsp_ready = (c < 7) ? 4'b1101 : 4'b1111;
            #1;
            if (c >= 4 && c < 7) begin
                total_cnt++; if (req_ready !== 4'b0) $display("FAIL bp_req_ready c%0d got %b exp 0000", c, req_ready); else pass_cnt++;
                total_cnt++; if (rsp_valid !== 4'b0010) $display("FAIL bp_rsp_valid c%0d got %b exp 0010", c, rsp_valid); else pass_cnt++;
                total_cnt++; if (rsp_data !== 30'd808) $display("FAIL bp_data c%0d got %0d exp 808", c, rsp_data); else pass_cnt++;
            end
            tick();
        end
        repeat (6) tick();
        total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL bp_count got %0d exp %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            total_cnt++; if (obs_q[k] !== exp_q[k]) $display("FAIL bp_sb[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); else pass_cnt++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        set_op(2, 15'd5, 15'd5);
        req_valid = 4'b0100;
        tick();
        tick();
        reset_n = 1'b0;
        req_valid = 4'b0000;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 4'b0) $display("FAIL rmid_rsp_valid got %b exp 0000", rsp_valid); else pass_cnt++;
        exp_q.delete();
        obs_q.delete();
        rsp_seen = 0;
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        total_cnt++; if (rsp_seen != 0) $display("FAIL rmid_stale_rsp got %0d exp 0", rsp_seen); else pass_cnt++;
        for (int i = 0; i < 4; i++) set_op(i, 15'(i + 20), 15'd2);
        req_valid = 4'b1111;
        #1;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL rmid_grant got %b exp 0001", req_ready); else pass_cnt++;
        tick();
        req_valid = 4'b0000;
        repeat (4) tick();
        total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL rmid_count got %0d exp %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            total_cnt++; if (obs_q[k] !== exp_q[k]) $display("FAIL rmid_sb[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); else pass_cnt++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        for (int c = 0; c < 10; c++) begin
            req_valid = {2'b01, 1'b0, c >= 4};
            set_op(2, 15'(200 + c), 15'd3);
            set_op(0, 15'(c), 15'd11);
            exp_g = (c < 4) ? 4'b0100 : (((c - 4) % 2 == 0) ? 4'b0001 : 4'b0100);
            #1;
            total_cnt++; if (req_ready !== exp_g) $display("FAIL fair_grant c%0d got %b exp %b", c, req_ready, exp_g); else pass_cnt++;
            tick();
        end
        req_valid = 4'b0000;
        repeat (4) tick();
        total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL fair_count got %0d exp %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            total_cnt++; if (obs_q[k] !== exp_q[k]) $display("FAIL fair_sb[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); else pass_cnt++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_max();
        test_round_robin();
        test_back_pressure();
        test_reset_mid();
        test_fairness();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
